// File: rtl/pong_pkg.sv
// Shared pong constants, quadrature FSM encoding and direction type.
// Also holds the Gray-code position helper used by the encoder decoder.
package pong_pkg;

  localparam int SWIDTH        = 640;
  localparam int SHEIGHT       = 480;
  localparam int PADDLE_HEIGHT = 25;
  localparam int PADDLE_SPEED  = 8;
  localparam int PADDLE_WIDTH  = 10;
  localparam int PADDLE_OFFSET = 20;
  localparam int BALL_SIZE     = 8;
  localparam int COORD_W       = 11;

  typedef enum logic {
    Q_INIT  = 1'b0,
    Q_TRACK = 1'b1
  } quad_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Position of {a,b} along the down sequence 00->01->11->10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      2'b10:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// One-bit synchroniser followed by a stable-count filter; o_stable means the
// synchronised input agrees with the filtered level and the counter is idle.
module quad_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_sync;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign o_level  = r_level;
  assign o_stable = (r_cnt == '0) && (w_sync == r_level);

  // Synchroniser shift and stable-count filter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_input_ctrl.sv
// Paddle position source: debounced quadrature encoder with step accumulation,
// saturating position update, and a per-frame autopilot that tracks the ball.
module paddle_input_ctrl
  import pong_pkg::*;
#(
  parameter int SHEIGHT         = pong_pkg::SHEIGHT,
  parameter int PADDLE_HEIGHT   = pong_pkg::PADDLE_HEIGHT,
  parameter int PADDLE_SPEED    = pong_pkg::PADDLE_SPEED,
  parameter int AUTO_SPEED      = 1,
  parameter int STEPS_PER_MOVE  = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 255,
  parameter int RESET_Y         = 240
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               auto_en,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle_y,
  output logic               moved,
  output logic               dir_down,
  output logic               illegal
);

  localparam logic [11:0] Y_MIN     = 12'(PADDLE_HEIGHT + 1);
  localparam logic [11:0] Y_MAX     = 12'(SHEIGHT - PADDLE_HEIGHT);
  localparam logic [11:0] MAN_STEP  = 12'(PADDLE_SPEED);
  localparam logic [11:0] AUTO_STEP = 12'(AUTO_SPEED);
  localparam logic [COORD_W-1:0] Y_RESET = COORD_W'(RESET_Y);
  localparam logic [2:0]  STEPS_TGT = 3'(STEPS_PER_MOVE);
  localparam int ICW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(DEBOUNCE_CYCLES - 1);

  logic w_a, w_b, w_a_stable, w_b_stable;
  logic [SYNC_STAGES-1:0] r_auto_sync;
  logic w_auto;

  quad_state_e  r_state;
  logic [ICW-1:0] r_init_cnt;
  logic [1:0]   r_prev;
  logic [1:0]   r_acc_cnt;
  dir_e         r_acc_dir;
  logic         r_step, r_step_down, r_illegal;

  logic [1:0]  w_cur, w_delta;
  logic        w_valid, w_down, w_bad;
  logic [2:0]  w_acc_sum;

  logic [COORD_W-1:0] r_y;
  logic        r_moved;
  dir_e        r_dir;
  logic        w_req, w_req_down;
  logic [11:0] w_amt, w_dn_sum, w_dn_y, w_up_y, w_new_y;

  quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset(reset), .i_raw(enc_a), .o_level(w_a), .o_stable(w_a_stable)
  );
  quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset(reset), .i_raw(enc_b), .o_level(w_b), .o_stable(w_b_stable)
  );

  // Autopilot switch synchroniser (level input, no filtering needed).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_auto_sync <= '0;
    end else begin
      r_auto_sync <= {r_auto_sync[SYNC_STAGES-2:0], auto_en};
    end
  end
  assign w_auto = r_auto_sync[SYNC_STAGES-1];

  assign w_cur   = {w_a, w_b};
  assign w_delta = gray_idx(w_cur) - gray_idx(r_prev);

  // Classify the filtered transition: +1 down, -1 up, 2 is a double-bit jump.
  always_comb begin
    w_valid = 1'b0;
    w_down  = 1'b0;
    w_bad   = 1'b0;
    case (w_delta)
      2'd1:    begin w_valid = 1'b1; w_down = 1'b1; end
      2'd3:    begin w_valid = 1'b1; w_down = 1'b0; end
      2'd2:    w_bad = 1'b1;
      default: w_valid = 1'b0;
    endcase
  end

  // Direction reversal restarts the count at one in the new direction.
  always_comb begin
    if ((r_acc_cnt != 2'd0) && (r_acc_dir != dir_e'(w_down))) begin
      w_acc_sum = 3'd1;
    end else begin
      w_acc_sum = {1'b0, r_acc_cnt} + 3'd1;
    end
  end

  // Quadrature FSM: acquire a settled starting phase, then decode steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= Q_INIT;
      r_init_cnt  <= '0;
      r_prev      <= 2'b00;
      r_acc_cnt   <= 2'd0;
      r_acc_dir   <= DIR_UP;
      r_step      <= 1'b0;
      r_step_down <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_step    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        Q_INIT: begin
          if (w_a_stable && w_b_stable) begin
            if (r_init_cnt == INIT_LAST) begin
              r_prev     <= w_cur;
              r_init_cnt <= '0;
              r_state    <= Q_TRACK;
            end else begin
              r_init_cnt <= r_init_cnt + 1'b1;
            end
          end else begin
            r_init_cnt <= '0;
          end
        end
        Q_TRACK: begin
          if (w_bad) begin
            r_illegal <= 1'b1;
            r_acc_cnt <= 2'd0;
            r_prev    <= w_cur;
          end else if (w_valid) begin
            r_prev    <= w_cur;
            r_acc_dir <= dir_e'(w_down);
            if (w_acc_sum == STEPS_TGT) begin
              r_acc_cnt   <= 2'd0;
              r_step      <= 1'b1;
              r_step_down <= w_down;
            end else begin
              r_acc_cnt <= w_acc_sum[1:0];
            end
          end
        end
        default: r_state <= Q_INIT;
      endcase
    end
  end

  // Select the move request: manual steps, or frame-paced ball tracking.
  always_comb begin
    w_req      = 1'b0;
    w_req_down = 1'b0;
    w_amt      = MAN_STEP;
    if (w_auto) begin
      w_amt = AUTO_STEP;
      if (frame_tick && (ball_y != r_y)) begin
        w_req      = 1'b1;
        w_req_down = (r_y < ball_y);
      end else begin
        w_req = 1'b0;
      end
    end else begin
      w_req      = r_step;
      w_req_down = r_step_down;
    end
  end

  // Saturating 12-bit target so neither bound can wrap.
  always_comb begin
    w_dn_sum = {1'b0, r_y} + w_amt;
    if (w_dn_sum > Y_MAX) begin
      w_dn_y = Y_MAX;
    end else begin
      w_dn_y = w_dn_sum;
    end
    if ({1'b0, r_y} < (Y_MIN + w_amt)) begin
      w_up_y = Y_MIN;
    end else begin
      w_up_y = {1'b0, r_y} - w_amt;
    end
    if (w_req_down) begin
      w_new_y = w_dn_y;
    end else begin
      w_new_y = w_up_y;
    end
  end

  // Position register; moved only fires when the value really changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y     <= Y_RESET;
      r_moved <= 1'b0;
      r_dir   <= DIR_UP;
    end else begin
      r_moved <= 1'b0;
      if (w_req && (w_new_y != {1'b0, r_y})) begin
        r_y     <= w_new_y[COORD_W-1:0];
        r_moved <= 1'b1;
        r_dir   <= dir_e'(w_req_down);
      end
    end
  end

  assign paddle_y = r_y;
  assign moved    = r_moved;
  assign dir_down = (r_dir == DIR_DOWN);
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed bench for paddle_input_ctrl with short debounce; a second instance
// with STEPS_PER_MOVE=4 shares all inputs.
module tb_paddle_input_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enc_a, enc_b, auto_en, frame_tick;
  logic [10:0] ball_y;
  logic [10:0] y1, y4;
  logic        mv1, mv4, dd1, dd4, il1, il4;

  int n_checks = 0;
  int n_fail   = 0;
  int mc1 = 0, mc4 = 0, ic1 = 0;
  int base_m, base_m4, base_i;
  logic [1:0] enc;

  paddle_input_ctrl #(.STEPS_PER_MOVE(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .auto_en(auto_en),
    .frame_tick(frame_tick), .ball_y(ball_y), .paddle_y(y1), .moved(mv1),
    .dir_down(dd1), .illegal(il1)
  );
  paddle_input_ctrl #(.STEPS_PER_MOVE(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .auto_en(auto_en),
    .frame_tick(frame_tick), .ball_y(ball_y), .paddle_y(y4), .moved(mv4),
    .dir_down(dd4), .illegal(il4)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (mv1) mc1 <= mc1 + 1;
    if (mv4) mc4 <= mc4 + 1;
    if (il1) ic1 <= ic1 + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_enc();
    enc_a = enc[1];
    enc_b = enc[0];
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] ab, input logic down);
    logic [1:0] r;
    if (down) begin
      case (ab)
        2'b00: r = 2'b01;
        2'b01: r = 2'b11;
        2'b11: r = 2'b10;
        default: r = 2'b00;
      endcase
    end else begin
      case (ab)
        2'b00: r = 2'b10;
        2'b10: r = 2'b11;
        2'b11: r = 2'b01;
        default: r = 2'b00;
      endcase
    end
    return r;
  endfunction

  task automatic step_enc(input logic down);
    enc = nxt(enc, down);
    apply_enc();
    cyc(10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; auto_en = 1'b0; frame_tick = 1'b0; ball_y = 11'd0;
    enc = 2'b11; apply_enc();

    // 1: reset with encoder at 11, re-acquire, then exact latency of one up step
    cyc(3);
    check_val("rst_y", y1, 240);
    check_val("rst_moved", mv1, 0);
    check_val("rst_dir", dd1, 0);
    check_val("rst_illegal", il1, 0);
    base_m = mc1; base_i = ic1;
    reset = 1'b0;
    cyc(20);
    check_val("t1_acq_y", y1, 240);
    check_val("t1_acq_no_move", mc1 - base_m, 0);
    check_val("t1_acq_no_illegal", ic1 - base_i, 0);
    base_m = mc1;
    enc = 2'b01; apply_enc();
    cyc(7);
    check_val("t1_before_latency", y1, 240);
    cyc(1);
    check_val("t1_at_latency", y1, 232);
    check_val("t1_moved_pulse", mv1, 1);
    check_val("t1_dir_up", dd1, 0);
    cyc(1);
    check_val("t1_moved_single", mv1, 0);
    check_val("t1_move_count", mc1 - base_m, 1);

    // 2: full down cycle; STEPS_PER_MOVE=4 instance moves once
    enc = 2'b00; apply_enc();
    do_reset();
    cyc(20);
    base_m = mc1; base_m4 = mc4;
    for (int i = 0; i < 4; i++) step_enc(1'b1);
    check_val("t2_y", y1, 272);
    check_val("t2_dir_down", dd1, 1);
    check_val("t2_moves", mc1 - base_m, 4);
    check_val("t2_s4_y", y4, 248);
    check_val("t2_s4_moves", mc4 - base_m4, 1);
    check_val("t2_s4_dir", dd4, 1);

    // 3: clamps at Y_MAX and Y_MIN (autopilot used to reach the start points)
    auto_en = 1'b1; ball_y = 11'd450; frame_tick = 1'b1;
    cyc(200);
    frame_tick = 1'b0; auto_en = 1'b0;
    cyc(5);
    check_val("t3_start_450", y1, 450);
    base_m = mc1;
    step_enc(1'b1);
    check_val("t3_clamp_max", y1, 455);
    step_enc(1'b1);
    step_enc(1'b1);
    check_val("t3_hold_max", y1, 455);
    check_val("t3_max_moves", mc1 - base_m, 1);
    auto_en = 1'b1; ball_y = 11'd30; frame_tick = 1'b1;
    cyc(450);
    frame_tick = 1'b0; auto_en = 1'b0;
    cyc(5);
    check_val("t3_start_30", y1, 30);
    base_m = mc1;
    step_enc(1'b0);
    check_val("t3_clamp_min", y1, 26);
    check_val("t3_min_dir", dd1, 0);
    step_enc(1'b0);
    step_enc(1'b0);
    check_val("t3_hold_min", y1, 26);
    check_val("t3_min_moves", mc1 - base_m, 1);

    // 4: short glitch rejected; double-bit jump flagged
    enc = 2'b00; apply_enc();
    do_reset();
    cyc(20);
    base_m = mc1; base_i = ic1;
    enc = 2'b10; apply_enc();
    cyc(3);
    enc = 2'b00; apply_enc();
    cyc(15);
    check_val("t4_glitch_y", y1, 240);
    check_val("t4_glitch_moves", mc1 - base_m, 0);
    check_val("t4_glitch_illegal", ic1 - base_i, 0);
    enc = 2'b11; apply_enc();
    cyc(10);
    check_val("t4_illegal_once", ic1 - base_i, 1);
    check_val("t4_illegal_y", y1, 240);
    check_val("t4_illegal_moves", mc1 - base_m, 0);

    // 5: autopilot tracks ball and ignores encoder steps
    auto_en = 1'b1; ball_y = 11'd100;
    cyc(4);
    base_m = mc1;
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      if (i == 0) check_val("t5_auto_latency", y1, 239);
      step_enc(1'b1);
    end
    check_val("t5_auto_y", y1, 235);
    check_val("t5_auto_moves", mc1 - base_m, 5);
    check_val("t5_auto_dir", dd1, 0);
    ball_y = 11'd235;
    frame_tick = 1'b1;
    cyc(3);
    frame_tick = 1'b0;
    cyc(1);
    check_val("t5_equal_hold", y1, 235);
    check_val("t5_equal_no_move", mc1 - base_m, 5);
    auto_en = 1'b0;
    cyc(4);
    ball_y = 11'd400;
    frame_tick = 1'b1;
    cyc(3);
    frame_tick = 1'b0;
    cyc(1);
    check_val("t5_manual_tick_ignored", y1, 235);

    // 6: reset lands one cycle after a step decodes
    do_reset();
    cyc(20);
    check_val("t6_reacq_y", y1, 240);
    step_enc(1'b1);
    check_val("t6_pre_y", y1, 248);
    base_m = mc1;
    enc = nxt(enc, 1'b1); apply_enc();
    cyc(7);
    reset = 1'b1;
    cyc(1);
    check_val("t6_reset_y", y1, 240);
    check_val("t6_reset_moved", mv1, 0);
    cyc(2);
    reset = 1'b0;
    cyc(20);
    check_val("t6_after_y", y1, 240);
    check_val("t6_after_moves", mc1 - base_m, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
